// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
// SPI modes are encoded as {cpol, cpha}.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // True when the mode samples MOSI on the leading SCLK edge.
  function automatic logic samples_on_leading(input logic [1:0] mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE2);
  endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Host-side byte interface of the SPI slave: transmit holding-buffer load and
// receive/status strobes, all in the system clock domain.
interface spi_slave_core_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_taken;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;

  modport slave (
    input  tx_data, tx_load,
    output tx_taken, rx_data, rx_valid, frame_err
  );

  modport master (
    output tx_data, tx_load,
    input  tx_taken, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer for an asynchronous pin, plus a one-register edge
// detector producing single-cycle rise/fall pulses. SYNC_STAGES must be >= 2.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint, all four CPOL/CPHA modes, oversampling SCLK/SS/MOSI on
// the system clock; MSB-first in both directions, multi-byte frames supported.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             SCLK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             miso_oe,
  spi_slave_core_if.slave  host
);

  localparam int                CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(SCLK),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .din(SS),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic smp_on_lead, lead_edge, trail_edge, smp_edge, sft_edge;

  assign smp_on_lead = samples_on_leading({cpol, cpha});
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign smp_edge    = smp_on_lead ? lead_edge : trail_edge;
  assign sft_edge    = smp_on_lead ? trail_edge : lead_edge;

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_taken_q, tx_taken_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              reload_q, reload_d;
  logic              pend_q, pend_d;
  logic              hold_q, hold_d;
  logic [DATA_W-1:0] load_val, rx_next;

  // reload: byte finished, next shift edge copies tx_buf into the shifter.
  // pend: that copy is only reported once the new byte's first sample arrives,
  // so a reload at the tail of the last byte of a frame is never announced.
  // hold: the first leading edge in cpha=1 drives the MSB without shifting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    tx_buf_d    = tx_buf_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    reload_d    = reload_q;
    pend_d      = pend_q;
    hold_d      = hold_q;
    rx_valid_d  = 1'b0;
    tx_taken_d  = 1'b0;
    frame_err_d = 1'b0;
    load_val    = host.tx_load ? host.tx_data : tx_buf_q;
    rx_next     = {shift_rx_q[DATA_W-2:0], mosi_lvl};

    if (host.tx_load) begin
      tx_buf_d = host.tx_data;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          cnt_d      = '0;
          shift_tx_d = load_val;
          miso_d     = load_val[DATA_W-1];
          tx_taken_d = 1'b1;
          reload_d   = 1'b0;
          pend_d     = 1'b0;
          hold_d     = ~smp_on_lead;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          frame_err_d = (cnt_q != '0);
          reload_d    = 1'b0;
          pend_d      = 1'b0;
          hold_d      = 1'b0;
        end else if (smp_edge) begin
          shift_rx_d = rx_next;
          if (pend_q) begin
            tx_taken_d = 1'b1;
            pend_d     = 1'b0;
          end
          if (cnt_q == LAST) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            reload_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sft_edge) begin
          if (reload_q) begin
            shift_tx_d = tx_buf_q;
            miso_d     = tx_buf_q[DATA_W-1];
            reload_d   = 1'b0;
            pend_d     = 1'b1;
          end else if (hold_q) begin
            miso_d = shift_tx_q[DATA_W-1];
            hold_d = 1'b0;
          end else begin
            shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
            miso_d     = shift_tx_q[DATA_W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_taken_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      reload_q    <= 1'b0;
      pend_q      <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_taken_q  <= tx_taken_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      reload_q    <= reload_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
    end
  end

  assign MISO           = miso_q;
  assign miso_oe        = ~ss_lvl;
  assign host.tx_taken  = tx_taken_q;
  assign host.rx_data   = rx_data_q;
  assign host.rx_valid  = rx_valid_q;
  assign host.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI master plus a model of the
// slave's holding buffer; vector table, random frames and corner sequences.
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic reset, cpol, cpha, SCLK, SS, MOSI;
  logic MISO, miso_oe;

  spi_slave_core_if #(.DATA_W(8)) bus ();

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO), .miso_oe(miso_oe),
    .host(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int          nb;
    logic [23:0] mw;
    logic [7:0]  txv;
    bit          ld;
    logic [23:0] exp_rx;
    logic [7:0]  exp_miso;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int taken_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] model_tx_buf;
  logic [7:0] exp_last_rx;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.rx_valid) rx_q.push_back(bus.rx_data);
      if (bus.tx_taken) taken_cnt++;
      if (bus.frame_err) fe_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    model_tx_buf = v;
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpol = m[1];
    cpha = m[0];
    SCLK = m[1];
    MOSI = 1'b0;
    wait_clk(4);
  endtask

  // Master side: drive MOSI MSB-first and capture MISO on the sample edge.
  task automatic clock_bits(input logic [23:0] mw, input int nbits, output logic [23:0] sw);
    sw = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        MOSI = mw[23-i];
        wait_clk(H);
        SCLK = ~cpol;
        sw = {sw[22:0], MISO};
        wait_clk(H);
        SCLK = cpol;
      end else begin
        wait_clk(H);
        SCLK = ~cpol;
        MOSI = mw[23-i];
        wait_clk(H);
        SCLK = cpol;
        sw = {sw[22:0], MISO};
      end
    end
  endtask

  task automatic frame_end();
    wait_clk(H);
    SS = 1'b1;
    wait_clk(8);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [23:0] sw;
    int rb, tb0, fb;
    set_mode(v.mode);
    if (v.ld) load(v.txv);
    rb = rx_q.size();
    tb0 = taken_cnt;
    fb = fe_cnt;
    SS = 1'b0;
    wait_clk(8);
    clock_bits(v.mw, v.nb * 8, sw);
    frame_end();
    chk({tag, " rx_cnt"}, 32'(rx_q.size() - rb), 32'(v.nb));
    for (int k = 0; k < v.nb; k++) begin
      chk($sformatf("%s rx%0d", tag, k),
          (rx_q.size() > rb + k) ? 32'(rx_q[rb+k]) : 32'hDEAD, 32'(v.exp_rx[23-8*k -: 8]));
      chk($sformatf("%s miso%0d", tag, k), 32'(sw[8*(v.nb-1-k) +: 8]), 32'(v.exp_miso));
    end
    chk({tag, " taken"}, 32'(taken_cnt - tb0), 32'(v.nb));
    chk({tag, " ferr"}, 32'(fe_cnt - fb), 32'd0);
    exp_last_rx = v.exp_rx[23-8*(v.nb-1) -: 8];
    chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(exp_last_rx));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " MISO"}, 32'(MISO), 32'd0);
    chk({tag, " miso_oe"}, 32'(miso_oe), 32'd0);
    chk({tag, " rx_data"}, 32'(bus.rx_data), 32'd0);
    chk({tag, " rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, " tx_taken"}, 32'(bus.tx_taken), 32'd0);
    chk({tag, " frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    logic [23:0] sw;
    int rb, tb0, fb;
    bit seen;

    tbl[0] = '{SPI_MODE0, 1, 24'h3C0000, 8'hA5, 1'b1, 24'h3C0000, 8'hA5};
    tbl[1] = '{SPI_MODE0, 1, 24'h810000, 8'h7E, 1'b1, 24'h810000, 8'h7E};
    tbl[2] = '{SPI_MODE1, 1, 24'h810000, 8'h7E, 1'b1, 24'h810000, 8'h7E};
    tbl[3] = '{SPI_MODE2, 1, 24'h810000, 8'h7E, 1'b1, 24'h810000, 8'h7E};
    tbl[4] = '{SPI_MODE3, 1, 24'h810000, 8'h7E, 1'b1, 24'h810000, 8'h7E};
    tbl[5] = '{SPI_MODE0, 3, 24'h112233, 8'hB0, 1'b1, 24'h112233, 8'hB0};
    tbl[6] = '{SPI_MODE3, 3, 24'hC4D5E6, 8'h00, 1'b0, 24'hC4D5E6, 8'hB0};

    reset = 1'b1;
    SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; cpol = 1'b0; cpha = 1'b0;
    bus.tx_load = 1'b0; bus.tx_data = '0;
    model_tx_buf = 8'h00;
    exp_last_rx = 8'h00;
    #1 reset = 1'b0;
    #1 chk_reset_outputs("por");
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // tx_load coinciding with the detected SS fall must bypass tx_buf.
    set_mode(SPI_MODE2);
    load(8'h5D);
    rb = rx_q.size(); tb0 = taken_cnt;
    SS = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (miso_oe) seen = 1'b1;
    end
    chk("bypass oe", 32'(seen), 32'd1);
    if (seen) begin
      bus.tx_data = 8'hC3;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
      model_tx_buf = 8'hC3;
    end
    wait_clk(8);
    clock_bits(24'h690000, 8, sw);
    frame_end();
    chk("bypass miso", 32'(sw[7:0]), 32'hC3);
    chk("bypass rx", (rx_q.size() > rb) ? 32'(rx_q[rb]) : 32'hDEAD, 32'h69);
    chk("bypass taken", 32'(taken_cnt - tb0), 32'd1);
    exp_last_rx = 8'h69;

    // SS rises after 5 bits: frame error, nothing received, rx_data held.
    set_mode(SPI_MODE1);
    rb = rx_q.size(); fb = fe_cnt;
    SS = 1'b0;
    wait_clk(8);
    clock_bits(24'hE70000, 5, sw);
    frame_end();
    chk("partial ferr", 32'(fe_cnt - fb), 32'd1);
    chk("partial rx_cnt", 32'(rx_q.size() - rb), 32'd0);
    chk("partial rx_data", 32'(bus.rx_data), 32'(exp_last_rx));
    v = '{SPI_MODE1, 1, 24'h5A0000, 8'h00, 1'b0, 24'h5A0000, model_tx_buf};
    run_vec(v, "after_partial");

    for (int i = 0; i < 8; i++) begin
      v.mode = 2'($urandom_range(0, 3));
      v.nb = $urandom_range(1, 3);
      v.mw = 24'($urandom);
      v.txv = 8'($urandom);
      v.ld = 1'($urandom_range(0, 1));
      v.exp_rx = v.mw;
      v.exp_miso = v.ld ? v.txv : model_tx_buf;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a byte; tx_buf returns to zero afterwards.
    set_mode(SPI_MODE0);
    load(8'h99);
    SS = 1'b0;
    wait_clk(8);
    clock_bits(24'hF00000, 4, sw);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_outputs("midbyte");
    model_tx_buf = 8'h00;
    SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(4);
    v = '{SPI_MODE0, 1, 24'hF00000, 8'h00, 1'b0, 24'hF00000, model_tx_buf};
    run_vec(v, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
